// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter driving a one-hot data mux: locks a grant for a burst,
// releases on last beat or after MAX_BEATS transfers, then rotates priority.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no grant; picks first requester from ptr onward, grants next cycle
// BUSY  | grant locked to g_idx; outputs follow requester g_idx combinationally
module rr_mux_arbiter #(
  parameter  int DATA_WIDTH = 32,
  parameter  int INPUTS     = 4,
  parameter  int MAX_BEATS  = 8,
  localparam int IW         = $clog2(INPUTS)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [INPUTS-1:0]     i_req,
  input  logic [DATA_WIDTH-1:0] i_data [INPUTS-1:0],
  input  logic [INPUTS-1:0]     i_last,
  input  logic                  i_ready,
  output logic [INPUTS-1:0]     o_gnt,
  output logic [IW-1:0]         o_src,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_last
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] ptr, ptr_nxt;
  logic [IW-1:0] g_idx, g_idx_nxt;
  logic [7:0]    beat_cnt, beat_cnt_nxt;
  logic [IW-1:0] pick;
  logic          found;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= IDLE;
      ptr      <= '0;
      g_idx    <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      g_idx    <= g_idx_nxt;
      beat_cnt <= beat_cnt_nxt;
    end
  end

  // First requester at or after ptr, wrapping modulo INPUTS.
  always_comb begin
    pick  = ptr;
    found = 1'b0;
    for (int i = 0; i < INPUTS; i++) begin
      int c;
      c = (int'(ptr) + i) % INPUTS;
      if (!found && i_req[c]) begin
        found = 1'b1;
        pick  = IW'(c);
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    ptr_nxt      = ptr;
    g_idx_nxt    = g_idx;
    beat_cnt_nxt = beat_cnt;
    o_gnt        = '0;
    o_src        = '0;
    o_valid      = 1'b0;
    o_data       = '0;
    o_last       = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          g_idx_nxt    = pick;
          beat_cnt_nxt = '0;
          state_nxt    = BUSY;
        end
      end
      BUSY: begin
        o_gnt[g_idx] = 1'b1;
        o_src        = g_idx;
        o_valid      = i_req[g_idx];
        o_data       = i_data[g_idx];
        o_last       = i_last[g_idx];
        if (o_valid && i_ready) begin
          // Release on the last beat or on the beat that reaches MAX_BEATS.
          if (o_last || (beat_cnt == 8'(MAX_BEATS - 1))) begin
            state_nxt    = IDLE;
            beat_cnt_nxt = '0;
            ptr_nxt      = (g_idx == IW'(INPUTS - 1)) ? '0 : g_idx + IW'(1);
          end else begin
            beat_cnt_nxt = beat_cnt + 8'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Bench for rr_mux_arbiter: directed burst scenarios plus random traffic,
// all checked cycle by cycle against a queue-free ownership model.
module tb_rr_mux_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int MB = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req, last, gnt;
  logic [DW-1:0] data [N-1:0];
  logic          rdy;
  logic [1:0]    src;
  logic          valid, olast;
  logic [DW-1:0] odata;

  int tests_run    = 0;
  int tests_failed = 0;

  // Model: owner is -1 when nobody holds the grant.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_cnt   = 0;

  always #5 clk = ~clk;

  rr_mux_arbiter #(.DATA_WIDTH(DW), .INPUTS(N), .MAX_BEATS(MB)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_req  (req),
    .i_data (data),
    .i_last (last),
    .i_ready(rdy),
    .o_gnt  (gnt),
    .o_src  (src),
    .o_valid(valid),
    .o_data (odata),
    .o_last (olast)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at posedge+1, compare at negedge, then advance the model
  // to what the following posedge should produce.
  task automatic step(input logic r, input logic [N-1:0] rq, input logic [N-1:0] ls, input logic rd);
    logic [N-1:0]  e_gnt;
    logic          e_valid, e_last;
    logic [DW-1:0] e_data;
    int            e_src;
    @(posedge clk);
    #1;
    rst  = r;
    req  = rq;
    last = ls;
    rdy  = rd;
    for (int i = 0; i < N; i++) data[i] = $urandom;
    #4;
    e_gnt   = '0;
    e_src   = 0;
    e_valid = 1'b0;
    e_data  = '0;
    e_last  = 1'b0;
    if (m_owner >= 0) begin
      e_gnt[m_owner] = 1'b1;
      e_src          = m_owner;
      e_valid        = rq[m_owner];
      e_data         = data[m_owner];
      e_last         = ls[m_owner];
    end
    check_val("gnt",    64'(gnt),   64'(e_gnt));
    check_val("src",    64'(src),   64'(e_src));
    check_val("valid",  64'(valid), 64'(e_valid));
    check_val("data",   64'(odata), 64'(e_data));
    check_val("last",   64'(olast), 64'(e_last));
    check_val("onehot", 64'($onehot0(gnt)), 64'(1));
    if (r) begin
      m_owner = -1;
      m_ptr   = 0;
      m_cnt   = 0;
    end else if (m_owner < 0) begin
      for (int k = N - 1; k >= 0; k--)
        if (rq[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
      m_cnt = 0;
    end else if (e_valid && rd) begin
      m_cnt++;
      if (e_last || m_cnt == MB) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
        m_cnt   = 0;
      end
    end
  endtask

  task automatic do_reset();
    step(1'b1, '0, '0, 1'b0);
  endtask

  initial begin
    int xfers;
    logic [N-1:0] rq, ls;
    rst  = 1'b1;
    req  = '0;
    last = '0;
    rdy  = 1'b0;
    for (int i = 0; i < N; i++) data[i] = '0;
    repeat (2) @(posedge clk);

    // Reset state, then REQ 0110: grant to 1, release, idle, grant to 2.
    step(1'b0, 4'b0000, 4'b0000, 1'b0);
    check_val("rst_gnt", 64'(gnt), 64'(0));
    check_val("rst_valid", 64'(valid), 64'(0));
    step(1'b0, 4'b0110, 4'b1111, 1'b0);
    check_val("s1_idle", 64'(gnt), 64'(0));
    step(1'b0, 4'b0110, 4'b1111, 1'b1);
    check_val("s1_gnt1", 64'(gnt), 64'(4'b0010));
    check_val("s1_src1", 64'(src), 64'(1));
    step(1'b0, 4'b0110, 4'b1111, 1'b1);
    check_val("s1_gap", 64'(gnt), 64'(0));
    step(1'b0, 4'b0110, 4'b1111, 1'b1);
    check_val("s1_gnt2", 64'(gnt), 64'(4'b0100));

    // All requesting with single-beat bursts: 0,1,2,3,0 with gaps.
    do_reset();
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 4'b1111, 4'b1111, 1'b1);
      check_val("rr_order", 64'(gnt), (k % 2 == 1) ? 64'(1) << ((k / 2) % N) : 64'(0));
    end

    // Requester 2 never signals last: forced release after MAX_BEATS.
    do_reset();
    xfers = 0;
    for (int k = 0; k < 11; k++) begin
      step(1'b0, 4'b1100, 4'b0000, 1'b1);
      if (gnt == 4'b0100 && valid) xfers++;
    end
    check_val("max_beats", 64'(xfers), 64'(MB));
    check_val("after_max", 64'(gnt), 64'(4'b1000));

    // Granted requester drops for 3 cycles; grant stays locked.
    do_reset();
    step(1'b0, 4'b0010, 4'b0000, 1'b1);
    step(1'b0, 4'b0010, 4'b0000, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 4'b0001, 4'b0000, 1'b1);
      check_val("drop_gnt", 64'(gnt), 64'(4'b0010));
      check_val("drop_valid", 64'(valid), 64'(0));
    end
    step(1'b0, 4'b0011, 4'b0010, 1'b1);
    check_val("resume_valid", 64'(valid), 64'(1));
    step(1'b0, 4'b0001, 4'b0000, 1'b1);
    check_val("resume_gap", 64'(gnt), 64'(0));
    step(1'b0, 4'b0001, 4'b0000, 1'b1);
    check_val("resume_next", 64'(gnt), 64'(4'b0001));

    // Backpressure: no transfer while ready is low.
    do_reset();
    step(1'b0, 4'b0001, 4'b0001, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 4'b0001, 4'b0001, 1'b0);
      check_val("bp_gnt", 64'(gnt), 64'(4'b0001));
    end
    step(1'b0, 4'b0001, 4'b0001, 1'b1);
    step(1'b0, 4'b0001, 4'b0001, 1'b0);
    check_val("bp_release", 64'(gnt), 64'(0));

    // Reset mid-burst, then 1001 goes to requester 0.
    do_reset();
    step(1'b0, 4'b1111, 4'b0000, 1'b1);
    step(1'b0, 4'b1111, 4'b0000, 1'b1);
    step(1'b0, 4'b1111, 4'b0000, 1'b1);
    step(1'b1, 4'b1111, 4'b0000, 1'b1);
    step(1'b0, 4'b1001, 4'b0000, 1'b1);
    check_val("abort_gnt", 64'(gnt), 64'(0));
    check_val("abort_data", 64'(odata), 64'(0));
    step(1'b0, 4'b1001, 4'b0000, 1'b1);
    check_val("abort_next", 64'(gnt), 64'(4'b0001));

    // Random traffic against the model.
    for (int k = 0; k < 600; k++) begin
      rq = N'($urandom);
      for (int i = 0; i < N; i++) ls[i] = ($urandom_range(0, 3) == 0);
      step(($urandom_range(0, 59) == 0), rq, ls, ($urandom_range(0, 3) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
